// File: rtl/seq_reg.sv
// seq_reg: sequence register for the Genius game datapath.
//
// Stores up to DEPTH colour symbols of SYM_W bits each. The sequence grows
// one symbol per append, and a parallel load can preset it. A read pointer
// lets playback and check logic step through the stored symbols in order.
//
// Optional feature macro: SEQ_REG_LFSR_EN
//   When it is defined, the block adds input APPEND_RND and a 16-bit Fibonacci
//   LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1). APPEND_RND appends the
//   symbol 1 << lfsr[1:0]. The default build has no random append.
//
// Ports
//   CLK        clock; all state changes on the rising edge
//   R          asynchronous active-low reset
//   CLR        synchronous clear of sequence, length, pointer and flags
//   LOAD       parallel load of data / load_len (length saturated to DEPTH)
//   data       parallel load image; symbol i at [SYM_W*i +: SYM_W]
//   load_len   length taken on LOAD
//   APPEND     append sym_in at index len
//   sym_in     symbol to append
//   RD_START   rewind read pointer to symbol 0
//   RD_NEXT    advance read pointer
//   q          full stored sequence; unused slots read 0
//   q_sym      symbol at rd_idx while rd_valid, else 0
//   len        number of valid symbols
//   rd_idx     read pointer
//   rd_valid   pointer addresses a valid symbol
//   rd_last    rd_valid and rd_idx == len-1
//   full       len == DEPTH
//   empty      len == 0
//   ovf        sticky: append attempted while full
module seq_reg #(
    parameter int SYM_W = 4,
    parameter int DEPTH = 16,
    parameter int LEN_W = 5
) (
    input  logic                   CLK,
    input  logic                   R,
    input  logic                   CLR,
    input  logic                   LOAD,
    input  logic [SYM_W*DEPTH-1:0] data,
    input  logic [LEN_W-1:0]       load_len,
    input  logic                   APPEND,
    input  logic [SYM_W-1:0]       sym_in,
`ifdef SEQ_REG_LFSR_EN
    input  logic                   APPEND_RND,
`endif
    input  logic                   RD_START,
    input  logic                   RD_NEXT,
    output logic [SYM_W*DEPTH-1:0] q,
    output logic [SYM_W-1:0]       q_sym,
    output logic [LEN_W-1:0]       len,
    output logic [LEN_W-1:0]       rd_idx,
    output logic                   rd_valid,
    output logic                   rd_last,
    output logic                   full,
    output logic                   empty,
    output logic                   ovf
);

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    logic [SYM_W*DEPTH-1:0] q_r;
    logic [LEN_W-1:0]       len_r;
    logic [LEN_W-1:0]       rd_idx_r;
    logic                   rd_valid_r;
    logic                   ovf_r;

    logic                   full_w;
    logic                   rd_last_w;
    logic [LEN_W-1:0]       eff_load_len;
    logic                   append_req;
    logic [SYM_W-1:0]       append_sym;

`ifdef SEQ_REG_LFSR_EN
    logic [15:0]            lfsr_r;
    logic [SYM_W-1:0]       rnd_sym;

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= {lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5], lfsr_r[15:1]};
        end
    end

    assign rnd_sym    = SYM_W'(1) << lfsr_r[1:0];
    // External append has priority over the random one.
    assign append_req = APPEND | APPEND_RND;
    assign append_sym = APPEND ? sym_in : rnd_sym;
`else
    assign append_req = APPEND;
    assign append_sym = sym_in;
`endif

    assign full_w       = (len_r == DEPTH_L);
    // rd_last uses the registered (pre-append) length, so a symbol appended in
    // the same cycle is not reached in the current playback pass.
    assign rd_last_w    = rd_valid_r && (rd_idx_r == (len_r - LEN_W'(1)));
    assign eff_load_len = (load_len > DEPTH_L) ? DEPTH_L : load_len;

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            q_r        <= '0;
            len_r      <= '0;
            rd_idx_r   <= '0;
            rd_valid_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else if (CLR) begin
            q_r        <= '0;
            len_r      <= '0;
            rd_idx_r   <= '0;
            rd_valid_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else if (LOAD) begin
            // Slots beyond the loaded length are zeroed so q never shows stale data.
            for (int i = 0; i < DEPTH; i++) begin
                if (LEN_W'(i) < eff_load_len) begin
                    q_r[SYM_W*i +: SYM_W] <= data[SYM_W*i +: SYM_W];
                end else begin
                    q_r[SYM_W*i +: SYM_W] <= '0;
                end
            end
            len_r      <= eff_load_len;
            rd_idx_r   <= '0;
            rd_valid_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            if (append_req) begin
                if (!full_w) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (len_r == LEN_W'(i)) begin
                            q_r[SYM_W*i +: SYM_W] <= append_sym;
                        end
                    end
                    len_r <= len_r + LEN_W'(1);
                end else begin
                    ovf_r <= 1'b1;
                end
            end

            if (RD_START) begin
                rd_idx_r   <= '0;
                rd_valid_r <= (len_r != '0);
            end else if (RD_NEXT && rd_valid_r) begin
                if (rd_last_w) begin
                    rd_valid_r <= 1'b0;
                end else begin
                    rd_idx_r <= rd_idx_r + LEN_W'(1);
                end
            end
        end
    end

    always_comb begin
        q_sym = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_valid_r && (rd_idx_r == LEN_W'(i))) begin
                q_sym = q_r[SYM_W*i +: SYM_W];
            end
        end
    end

    assign q        = q_r;
    assign len      = len_r;
    assign rd_idx   = rd_idx_r;
    assign rd_valid = rd_valid_r;
    assign rd_last  = rd_last_w;
    assign full     = full_w;
    assign empty    = (len_r == '0);
    assign ovf      = ovf_r;

endmodule

// File: tb/tb_seq_reg.sv
// Self-checking bench for seq_reg (default parameters). The reference model
// keeps the sequence as a queue of symbols plus an index/valid pair for the
// read pointer. It is updated on every clock edge from the applied requests.
module tb_seq_reg;

    logic        CLK = 1'b0;
    logic        R = 1'b1;
    logic        CLR = 1'b0, LOAD = 1'b0, APPEND = 1'b0, RD_START = 1'b0, RD_NEXT = 1'b0;
    logic [63:0] data = '0;
    logic [4:0]  load_len = '0;
    logic [3:0]  sym_in = '0;
`ifdef SEQ_REG_LFSR_EN
    logic        APPEND_RND = 1'b0;
`endif
    logic [63:0] q;
    logic [3:0]  q_sym;
    logic [4:0]  len, rd_idx;
    logic        rd_valid, rd_last, full, empty, ovf;

    seq_reg dut (
        .CLK(CLK), .R(R), .CLR(CLR), .LOAD(LOAD), .data(data), .load_len(load_len),
        .APPEND(APPEND), .sym_in(sym_in),
`ifdef SEQ_REG_LFSR_EN
        .APPEND_RND(APPEND_RND),
`endif
        .RD_START(RD_START), .RD_NEXT(RD_NEXT), .q(q), .q_sym(q_sym), .len(len),
        .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_last(rd_last), .full(full),
        .empty(empty), .ovf(ovf)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    logic [3:0]  mq[$];
    int          m_idx;
    bit          m_valid, m_ovf, m_last, m_rnd;
    int          m_old, m_n;
    logic [15:0] m_lfsr;
    logic [3:0]  m_rsym;

    always @(posedge CLK or negedge R) begin
        if (!R) begin
            mq.delete();
            m_idx = 0; m_valid = 0; m_ovf = 0;
            m_lfsr = 16'hACE1;
        end else begin
            m_rnd = 0;
`ifdef SEQ_REG_LFSR_EN
            m_rnd = APPEND_RND;
`endif
            m_rsym = 4'(1 << m_lfsr[1:0]);
            if (CLR) begin
                mq.delete();
                m_idx = 0; m_valid = 0; m_ovf = 0;
            end else if (LOAD) begin
                mq.delete();
                m_n = (load_len > 16) ? 16 : int'(load_len);
                for (int i = 0; i < m_n; i++) mq.push_back(data[4*i +: 4]);
                m_idx = 0; m_valid = 0; m_ovf = 0;
            end else begin
                m_old  = mq.size();
                m_last = m_valid && (m_idx == m_old - 1);
                if (APPEND || m_rnd) begin
                    if (m_old < 16) mq.push_back(APPEND ? sym_in : m_rsym);
                    else m_ovf = 1;
                end
                if (RD_START) begin
                    m_idx = 0; m_valid = (m_old != 0);
                end else if (RD_NEXT && m_valid) begin
                    if (m_last) m_valid = 0;
                    else m_idx++;
                end
            end
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
    end

    function automatic logic [82:0] exp_vec();
        logic [63:0] eq = '0;
        logic [3:0]  qs = '0;
        int          sz = mq.size();
        bit          lst;
        for (int i = 0; i < sz; i++) eq[4*i +: 4] = mq[i];
        if (m_valid) qs = mq[m_idx];
        lst = m_valid && (m_idx == sz - 1);
        return {eq, 5'(sz), 5'(m_idx), m_valid, lst, (sz == 16), (sz == 0), m_ovf, qs};
    endfunction

    logic [82:0] act_vec;
    assign act_vec = {q, len, rd_idx, rd_valid, rd_last, full, empty, ovf, q_sym};

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        CLR = 0; LOAD = 0; APPEND = 0; RD_START = 0; RD_NEXT = 0;
`ifdef SEQ_REG_LFSR_EN
        APPEND_RND = 0;
`endif
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
        idle();
    endtask

    task automatic do_clr();
        CLR = 1; cyc();
    endtask

    task automatic do_append(input logic [3:0] s);
        APPEND = 1; sym_in = s; cyc();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 R = 0;
        #1;
        n_cmp++;
        if ({q, len, empty, q_sym, ovf, full, rd_valid, rd_last} !== {64'h0, 5'd0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_async: q=%h len=%0d empty=%b q_sym=%h ovf=%b full=%b rd_valid=%b rd_last=%b, required all zero with empty=1",
                     q, len, empty, q_sym, ovf, full, rd_valid, rd_last);
        end
        cyc(); cyc();
        R = 1;
        cyc();
        n_cmp++;
        if (act_vec !== exp_vec() || len !== 5'd0 || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release: got %h required %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_append_playback();
        do_clr();
        do_append(4'b0001); do_append(4'b0100); do_append(4'b1000);
        n_cmp++;
        if (len !== 5'd3 || q[11:0] !== 12'h841 || q[63:12] !== '0) begin
            n_bad++;
            $display("FAIL append3: len=%0d q=%h, required len=3 q=841", len, q);
        end
        RD_START = 1; cyc();
        n_cmp++;
        if (q_sym !== 4'h1 || rd_valid !== 1'b1 || rd_last !== 1'b0) begin
            n_bad++;
            $display("FAIL play0: q_sym=%h valid=%b last=%b, required 1/1/0", q_sym, rd_valid, rd_last);
        end
        RD_NEXT = 1; cyc();
        n_cmp++;
        if (q_sym !== 4'h4 || rd_last !== 1'b0) begin
            n_bad++;
            $display("FAIL play1: q_sym=%h last=%b, required 4/0", q_sym, rd_last);
        end
        RD_NEXT = 1; cyc();
        n_cmp++;
        if (q_sym !== 4'h8 || rd_last !== 1'b1 || rd_idx !== 5'd2) begin
            n_bad++;
            $display("FAIL play2: q_sym=%h last=%b idx=%0d, required 8/1/2", q_sym, rd_last, rd_idx);
        end
        RD_NEXT = 1; cyc();
        n_cmp++;
        if (rd_valid !== 1'b0 || q_sym !== 4'h0 || rd_idx !== 5'd2 || rd_last !== 1'b0) begin
            n_bad++;
            $display("FAIL play_end: valid=%b q_sym=%h idx=%0d last=%b, required 0/0/2/0", rd_valid, q_sym, rd_idx, rd_last);
        end
        RD_NEXT = 1; cyc();
        n_cmp++;
        if (act_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL next_idle: got %h required %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_fill_overflow();
        logic [63:0] snap;
        do_clr();
        for (int i = 0; i < 16; i++) begin
            do_append(4'($urandom_range(1, 15)));
            if (i == 14) begin
                n_cmp++;
                if (full !== 1'b0 || len !== 5'd15) begin
                    n_bad++;
                    $display("FAIL fill15: full=%b len=%0d, required 0/15", full, len);
                end
            end
        end
        n_cmp++;
        if (full !== 1'b1 || len !== 5'd16 || ovf !== 1'b0 || act_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL fill16: full=%b len=%0d ovf=%b vec=%h required vec=%h", full, len, ovf, act_vec, exp_vec());
        end
        snap = q;
        do_append(4'hF);
        n_cmp++;
        if (len !== 5'd16 || q !== snap || ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow: len=%0d q=%h ovf=%b, required 16 %h 1", len, q, ovf, snap);
        end
        do_clr();
        n_cmp++;
        if (ovf !== 1'b0 || empty !== 1'b1 || q !== 64'h0) begin
            n_bad++;
            $display("FAIL clr_after_ovf: ovf=%b empty=%b q=%h, required 0/1/0", ovf, empty, q);
        end
    endtask

    task automatic test_load();
        LOAD = 1; data = 64'hFFFF_FFFF_FFFF_FFFF; load_len = 5'd5; cyc();
        n_cmp++;
        if (q !== 64'h0000_0000_000F_FFFF || len !== 5'd5 || rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL load5: q=%h len=%0d valid=%b, required 000fffff 5 0", q, len, rd_valid);
        end
        LOAD = 1; load_len = 5'd31; cyc();
        n_cmp++;
        if (len !== 5'd16 || full !== 1'b1 || q !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_bad++;
            $display("FAIL load31: len=%0d full=%b q=%h, required 16 1 all-F", len, full, q);
        end
        LOAD = 1; data = {$urandom, $urandom}; load_len = 5'd0; cyc();
        n_cmp++;
        if (empty !== 1'b1 || q !== 64'h0) begin
            n_bad++;
            $display("FAIL load0: empty=%b q=%h, required 1 0", empty, q);
        end
    endtask

    task automatic test_back_to_back();
        // CLR + LOAD + APPEND together: clear wins
        LOAD = 1; data = {$urandom, $urandom}; load_len = 5'd9; cyc();
        CLR = 1; LOAD = 1; APPEND = 1; sym_in = 4'h2; load_len = 5'd7; cyc();
        n_cmp++;
        if ({q, len, empty, ovf, rd_valid} !== {64'h0, 5'd0, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL clr_load_append: q=%h len=%0d empty=%b, required cleared", q, len, empty);
        end
        // RD_START + RD_NEXT together: start wins
        LOAD = 1; data = 64'h0000_0000_0000_0248; load_len = 5'd3; cyc();
        RD_START = 1; cyc();
        RD_NEXT = 1; cyc();
        RD_START = 1; RD_NEXT = 1; cyc();
        n_cmp++;
        if (rd_idx !== 5'd0 || rd_valid !== 1'b1 || q_sym !== 4'h8) begin
            n_bad++;
            $display("FAIL start_next: idx=%0d valid=%b q_sym=%h, required 0 1 8", rd_idx, rd_valid, q_sym);
        end
        // APPEND in the cycle rd_last is consumed
        RD_NEXT = 1; cyc();
        RD_NEXT = 1; cyc();
        APPEND = 1; sym_in = 4'h1; RD_NEXT = 1; cyc();
        n_cmp++;
        if (rd_valid !== 1'b0 || len !== 5'd4 || rd_idx !== 5'd2 || q[15:12] !== 4'h1) begin
            n_bad++;
            $display("FAIL append_on_last: valid=%b len=%0d idx=%0d q=%h, required 0 4 2 slot3=1", rd_valid, len, rd_idx, q);
        end
        // RD_START on empty with same-cycle append sees the old length
        do_clr();
        RD_START = 1; APPEND = 1; sym_in = 4'h4; cyc();
        n_cmp++;
        if (rd_valid !== 1'b0 || len !== 5'd1) begin
            n_bad++;
            $display("FAIL start_append_empty: valid=%b len=%0d, required 0 1", rd_valid, len);
        end
        // asynchronous reset mid-playback
        RD_START = 1; cyc();
        #2 R = 0;
        #1;
        n_cmp++;
        if (rd_valid !== 1'b0 || len !== 5'd0 || q !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_mid_play: valid=%b len=%0d q=%h, required 0 0 0", rd_valid, len, q);
        end
        cyc();
        R = 1;
        cyc();
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 99);
            CLR      = (r < 3);
            LOAD     = (r >= 3 && r < 8);
            APPEND   = ($urandom_range(0, 99) < 45);
            RD_START = ($urandom_range(0, 99) < 10);
            RD_NEXT  = ($urandom_range(0, 99) < 50);
`ifdef SEQ_REG_LFSR_EN
            APPEND_RND = ($urandom_range(0, 99) < 15);
`endif
            sym_in   = 4'($urandom);
            data     = {$urandom, $urandom};
            load_len = 5'($urandom_range(0, 31));
            cyc();
            n_cmp++;
            if (act_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL random[%0d]: got %h required %h", c, act_vec, exp_vec());
            end
        end
    endtask

`ifdef SEQ_REG_LFSR_EN
    task automatic test_lfsr();
        #2 R = 0;
        cyc();
        R = 1;
        for (int i = 0; i < 4; i++) begin
            APPEND_RND = 1; cyc();
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (!$onehot(q[4*i +: 4])) begin
                n_bad++;
                $display("FAIL lfsr_onehot[%0d]: got %h, required a one-hot symbol", i, q[4*i +: 4]);
            end
        end
        n_cmp++;
        if (act_vec !== exp_vec() || len !== 5'd4) begin
            n_bad++;
            $display("FAIL lfsr_seq: got %h required %h", act_vec, exp_vec());
        end
        APPEND = 1; APPEND_RND = 1; sym_in = 4'h6; cyc();
        n_cmp++;
        if (q[19:16] !== 4'h6 || len !== 5'd5) begin
            n_bad++;
            $display("FAIL lfsr_priority: slot4=%h len=%0d, required 6 5", q[19:16], len);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_append_playback();
        test_fill_overflow();
        test_load();
        test_back_to_back();
        test_random();
`ifdef SEQ_REG_LFSR_EN
        test_lfsr();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_reg.md
# seq_reg

Parametrised sequence register for the Genius game datapath. It stores up to DEPTH colour symbols of SYM_W bits each and grows the sequence one symbol per round via append. It also supports a full parallel load for preset sequences. An internal read pointer lets the playback and check logic step through the stored sequence symbol by symbol.

## Interface
- SYM_W, default 4: bits per symbol (one-hot colour).
- DEPTH, default 16: maximum number of symbols; the default gives the 64-bit sequence.
- LEN_W, default 5: width of length and index counts, equal to $clog2(DEPTH+1).
- CLK  in  1  clock; all state changes on its rising edge.
- R  in  1  reset, asynchronous, active-low.
- CLR  in  1  synchronous clear of sequence, length, pointer and flags.
- LOAD  in  1  parallel load of data and load_len.
- data  in  SYM_W*DEPTH  parallel load image; symbol i sits at [SYM_W*i +: SYM_W].
- load_len  in  LEN_W  length taken on LOAD, saturated to DEPTH.
- APPEND  in  1  append sym_in at index len.
- sym_in  in  SYM_W  symbol to append.
- RD_START  in  1  rewind the read pointer to symbol 0.
- RD_NEXT  in  1  advance the read pointer.
- q  out  SYM_W*DEPTH  full stored sequence; unused slots read 0.
- q_sym  out  SYM_W  symbol at rd_idx while rd_valid, else 0.
- len  out  LEN_W  number of valid symbols.
- rd_idx  out  LEN_W  read pointer.
- rd_valid  out  1  pointer addresses a valid symbol.
- rd_last  out  1  rd_valid and rd_idx == len-1.
- full, empty  out  1 each  len == DEPTH; len == 0.
- ovf  out  1  sticky: an APPEND was attempted while full.

## Operation
- Write priority per cycle: CLR, then LOAD, then APPEND. Only the highest active request takes effect.
- CLR:
  - q = 0, len = 0, rd_idx = 0, rd_valid = 0, ovf = 0.
- LOAD:
  - q = data with slots at index ≥ min(load_len, DEPTH) forced to 0.
  - len = min(load_len, DEPTH).
  - rd_idx = 0, rd_valid = 0, ovf = 0.
- APPEND when not full: slot[len] = sym_in, len += 1.
- APPEND when full: storage and len unchanged, ovf = 1.
- Read pointer, evaluated only when no CLR or LOAD occurs; RD_START wins over RD_NEXT:
  - RD_START: rd_idx = 0, rd_valid = (len != 0), using len before any same-cycle append.
  - RD_NEXT with rd_valid and not rd_last: rd_idx += 1.
  - RD_NEXT with rd_last: rd_valid = 0; rd_idx holds.
  - RD_NEXT with rd_valid = 0: ignored.
- APPEND together with RD_NEXT: rd_last is computed from the pre-append len, so the newly appended symbol is not reached in that pass.
- Outputs q_sym, rd_last, full, empty are combinational from registered state only.

## Timing
- Reset (R low, asynchronous) drives q = 0, len = 0, rd_idx = 0, rd_valid = 0, ovf = 0. This also gives q_sym = 0, rd_last = 0, full = 0, empty = 1.
- Reset deasserts synchronously into normal operation; reset mid-playback aborts it immediately.
- Write latency is 1 cycle: data from LOAD or APPEND at edge n is visible on q, len and q_sym after edge n.
- One append per cycle sustained until full; the DEPTH-th append sets full in the same update.
- No handshake stalls; all requests are single-cycle pulses sampled at each edge.

## Configuration
- SEQ_REG_LFSR_EN defined:
  - Adds input APPEND_RND (1 bit) and an internal 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - The LFSR is seeded to 16'hACE1 on reset and advances every cycle.
  - APPEND_RND appends the symbol 1 << lfsr[1:0] (SYM_W ≥ 4 required); all other bits are 0. It follows the same full/ovf rules as APPEND.
  - APPEND takes priority over APPEND_RND when both are active.
- SEQ_REG_LFSR_EN undefined: no APPEND_RND port and no LFSR logic; only external append exists.

## Test plan
- Reset check: R low then high → q=0, len=0, empty=1, q_sym=0, ovf=0.
- Append with defaults: APPEND sym_in=4'b0001, then 4'b0100, then 4'b1000 → len=3, q[11:0]=12'h841. Then RD_START followed by three RD_NEXT → q_sym shows 1, 4, 8; rd_last is high on the third symbol; rd_valid=0 after.
- Fill and overflow: 16 appends → full=1, len=16. A 17th APPEND → len stays 16, q unchanged, ovf=1. Then CLR → ovf=0, empty=1.
- Parallel load:
  - LOAD data=64'hFFFF_FFFF_FFFF_FFFF, load_len=5 → q=64'h0000_0000_000F_FFFF, len=5.
  - LOAD with load_len=31 → len=16.
- Simultaneous requests:
  - CLR+LOAD+APPEND in one cycle → cleared state.
  - RD_START+RD_NEXT in one cycle → rd_idx=0.
  - APPEND on the cycle rd_last is consumed → playback ends; len increments.
- With SEQ_REG_LFSR_EN: 4 APPEND_RND pulses after reset → each stored symbol is one-hot and matches the reference LFSR model seeded 16'hACE1.
